// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared constants for the DMEM access controller: access-size
//                codes, FSM state encoding and the default DMEM depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Default DMEM depth: 2**8 = 256 words
  localparam int DEPTH_LOG2_DEF = 8;

  // Access-size codes carried on req_size (2'd3 is reserved)
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Controller FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_MERGE = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_unit.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_unit
//  Description : Combinational byte-lane logic for the DMEM controller.
//                Load path selects the addressed byte/half of the DMEM word and
//                sign- or zero-extends it. Store path replaces the addressed
//                byte/half of the DMEM word with the low bits of the store data.
//  Ports       : size        - access size code (SZ_*)
//                lane        - byte address bits [1:0]
//                is_unsigned - 1 = zero-extend loads, 0 = sign-extend
//                rd_word     - word read from DMEM
//                wdata       - right-aligned store data
//                load_data   - extended load result
//                merge_data  - read-modify-write merged word
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_byte_mask;

  always_comb begin
    w_shamt     = {lane, 3'b000};
    w_shifted   = rd_word >> w_shamt;
    w_byte      = w_shifted[7:0];
    // Halfword lanes are selected by address bit 1 only; bit 0 is zero for
    // any halfword access that reaches this unit.
    w_half      = lane[1] ? rd_word[31:16] : rd_word[15:0];
    w_byte_mask = 32'h0000_00FF << w_shamt;

    load_data = 32'h0;
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: load_data = {{16{~is_unsigned & w_half[15]}}, w_half};
      SZ_WORD: load_data = rd_word;
      default: load_data = 32'h0;
    endcase

    merge_data = rd_word;
    case (size)
      SZ_BYTE: merge_data = (rd_word & ~w_byte_mask) |
                            (({24'h0, wdata[7:0]} << w_shamt) & w_byte_mask);
      SZ_HALF: merge_data = lane[1] ? {wdata[15:0], rd_word[15:0]}
                                    : {rd_word[31:16], wdata[15:0]};
      SZ_WORD: merge_data = wdata;
      default: merge_data = rd_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_access_ctrl
//  Description : Initiator-side controller for the word-organised DMEM.
//                Accepts byte/half/word loads and stores over valid/ready,
//                performs sub-word extraction on loads and read-modify-write
//                on sub-word stores, and returns one response per request with
//                an error flag for misaligned/out-of-range/reserved accesses.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                req_*                      - request channel (valid/ready)
//                resp_valid/err/rdata       - one-cycle response strobe
//                DMEM_*                     - DMEM port (combinational read)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter logic [31:0] ERR_RDATA  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] DMEM_address,
  output logic [31:0] DMEM_data_in,
  output logic        DMEM_mem_write,
  output logic        DMEM_mem_read,
  input  logic [31:0] DMEM_data_out
);

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic [31:0] r_merged;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_address;

  logic        w_accept;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_req_err;
  logic [31:0] w_word_index;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  // ------------------------------------------------------------------------
  // Request decode
  // ------------------------------------------------------------------------
  assign w_accept       = req_valid & req_ready;
  assign w_misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                          ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                          (req_size == 2'd3);
  assign w_out_of_range = (req_addr >> (DEPTH_LOG2 + 2)) != 32'h0;
  assign w_req_err      = w_misaligned | w_out_of_range;
  assign w_word_index   = {{(32-DEPTH_LOG2){1'b0}}, req_addr[DEPTH_LOG2+1:2]};

  // ------------------------------------------------------------------------
  // Lane extract / merge
  // ------------------------------------------------------------------------
  dmem_lane_unit u_lane (
    .size        (r_size),
    .lane        (r_lane),
    .is_unsigned (r_unsigned),
    .rd_word     (DMEM_data_out),
    .wdata       (r_wdata),
    .load_data   (w_load_data),
    .merge_data  (w_merge_data)
  );

  // ------------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_req_err)               w_state_nxt = ST_RESP;
          else if (!req_write)         w_state_nxt = ST_LOAD;
          else if (req_size == SZ_WORD) w_state_nxt = ST_WRITE;
          else                         w_state_nxt = ST_MERGE;
        end
      end
      ST_LOAD:  w_state_nxt = ST_RESP;
      ST_MERGE: w_state_nxt = ST_WRITE;
      ST_WRITE: w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_lane     <= 2'd0;
      r_wdata    <= 32'h0;
      r_merged   <= 32'h0;
      r_err      <= 1'b0;
      r_rdata    <= 32'h0;
      r_address  <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_lane     <= req_addr[1:0];
        r_wdata    <= req_wdata;
        r_address  <= w_word_index;
        r_err      <= w_req_err;
        // Stores and good loads start from zero; loads overwrite in ST_LOAD.
        r_rdata    <= w_req_err ? ERR_RDATA : 32'h0;
      end
      if (r_state == ST_LOAD)  r_rdata  <= w_load_data;
      if (r_state == ST_MERGE) r_merged <= w_merge_data;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs, decoded from state so reset removes them immediately
  // ------------------------------------------------------------------------
  assign req_ready      = (r_state == ST_IDLE);
  assign resp_valid     = (r_state == ST_RESP);
  assign resp_err       = (r_state == ST_RESP) & r_err;
  assign resp_rdata     = (r_state == ST_RESP) ? r_rdata : 32'h0;
  assign DMEM_address   = r_address;
  assign DMEM_mem_read  = (r_state == ST_LOAD) || (r_state == ST_MERGE);
  assign DMEM_mem_write = (r_state == ST_WRITE);
  assign DMEM_data_in   = (r_state != ST_WRITE) ? 32'h0 :
                          (r_size == SZ_WORD)   ? r_wdata : r_merged;

endmodule
`default_nettype wire
